// File: rtl/ram_pkg.sv
// Shared constants and the parity helper for the ram block.
// The parity helper is only referenced when RAM_PARITY_EN is defined.
package ram_pkg;
  localparam int RAM_ADDR_BITS_DEF   = 4;
  localparam int RAM_DATA_BITS_DEF   = 8;
  localparam int RAM_PARITY_MAX_BITS = 64;

  // Even-parity bit: makes the total count of ones (word + bit) even.
  // Narrower words are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic even_parity(input logic [RAM_PARITY_MAX_BITS-1:0] word);
    return ^word;
  endfunction
endpackage

// File: rtl/ram_bus_driver.sv
// Tri-state output stage for the shared ram data bus.
// Drives the read word while enabled, otherwise releases every line to Z.
module ram_bus_driver
  import ram_pkg::*;
#(
  parameter int DATA_BITS = RAM_DATA_BITS_DEF
) (
  input  logic                 en_i,
  input  logic [DATA_BITS-1:0] word_i,
  output wire  [DATA_BITS-1:0] bus_o
);
  assign bus_o = en_i ? word_i : {DATA_BITS{1'bz}};
endmodule

// File: rtl/ram.sv
// Single-port RAM: synchronous write, combinational read, shared tri-state data bus.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose parity_err.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int DATA_BITS = RAM_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] address,
  inout  wire  [DATA_BITS-1:0] data,
  input  logic                 out_en,
  input  logic                 write_en
`ifdef RAM_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef RAM_PARITY_EN
  localparam int STORE_BITS = DATA_BITS + 1;
`else
  localparam int STORE_BITS = DATA_BITS;
`endif

  logic [STORE_BITS-1:0] wr_word;
  logic [STORE_BITS-1:0] rd_words [DEPTH];
  logic [STORE_BITS-1:0] rd_word;
  logic                  drive_en;

`ifdef RAM_PARITY_EN
  assign wr_word = {even_parity(RAM_PARITY_MAX_BITS'(data)), data};
`else
  assign wr_word = data;
`endif

  // One register per word so reset can clear the whole array at once.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [STORE_BITS-1:0] word_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= '0;
      end else if (write_en && (address == ADDR_BITS'(gi))) begin
        word_q <= wr_word;
      end
    end

    assign rd_words[gi] = word_q;
  end

  assign rd_word  = rd_words[address];
  // A write always wins the bus, so the external writer never sees contention.
  assign drive_en = out_en & ~write_en & ~reset;

  ram_bus_driver #(
    .DATA_BITS(DATA_BITS)
  ) u_bus_driver (
    .en_i  (drive_en),
    .word_i(rd_word[DATA_BITS-1:0]),
    .bus_o (data)
  );

`ifdef RAM_PARITY_EN
  assign parity_err = out_en & ~write_en &
                      (rd_word[DATA_BITS] != even_parity(RAM_PARITY_MAX_BITS'(rd_word[DATA_BITS-1:0])));
`endif
endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios plus random traffic against an array model.
// A weak pull-up on the bus makes a released bus read as all ones.
module tb_ram;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] RELEASED = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          out_en;
  logic          write_en;
  logic [AW-1:0] address;
  logic          tb_oe;
  logic [DW-1:0] tb_wdata;
  wire  [DW-1:0] data;
`ifdef RAM_PARITY_EN
  logic          parity_err;
`endif

  assign data = tb_oe ? tb_wdata : {DW{1'bz}};

  for (genvar gi = 0; gi < DW; gi++) begin : g_pu
    pullup (data[gi]);
  end

  ram #(
    .ADDR_BITS(AW),
    .DATA_BITS(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .out_en    (out_en),
    .write_en  (write_en)
`ifdef RAM_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] model [DEPTH];

  // Stimulus driver only: one write across a rising edge, model follows the rules.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    address  = a;
    tb_wdata = v;
    tb_oe    = 1'b1;
    write_en = 1'b1;
    out_en   = 1'b0;
    @(posedge clk);
    if (!reset) model[a] = v;
    #1;
    write_en = 1'b0;
    tb_oe    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_en = 1'b1; #1;
    tests++;
    if (data !== RELEASED) begin
      fails++; $display("FAIL reset_bus_release: got %h expected %h", data, RELEASED);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i); #1;
      tests++;
      if (data !== model[i]) begin
        fails++; $display("FAIL reset_read@%0d: got %h expected %h", i, data, model[i]);
      end
    end
    out_en = 1'b0; #1;
    tests++;
    if (data !== RELEASED) begin
      fails++; $display("FAIL out_en0_release: got %h expected %h", data, RELEASED);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential_writes();
    for (int i = 0; i < 3; i++) do_write(AW'(i), DW'(i));
    out_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = AW'(i); #1;
      tests++;
      if (data !== DW'(i)) begin
        fails++; $display("FAIL seq_read@%0d: got %h expected %h", i, data, DW'(i));
      end
    end
    out_en = 1'b0;
    $display("[TB] test_sequential_writes done");
  endtask

  task automatic test_overwrite_boundary();
    do_write(4'd15, 8'hAA);
    do_write(4'd15, 8'h55);
    do_write(4'd0, 8'hFF);
    out_en = 1'b1;
    address = 4'd15; #1;
    tests++;
    if (data !== 8'h55) begin
      fails++; $display("FAIL overwrite@15: got %h expected 55", data);
    end
    address = 4'd0; #1;
    tests++;
    if (data !== 8'hFF) begin
      fails++; $display("FAIL boundary@0: got %h expected ff", data);
    end
    for (int i = 1; i < 15; i++) begin
      address = AW'(i); #1;
      tests++;
      if (data !== model[i]) begin
        fails++; $display("FAIL unchanged@%0d: got %h expected %h", i, data, model[i]);
      end
    end
    out_en = 1'b0;
    $display("[TB] test_overwrite_boundary done");
  endtask

  task automatic test_contention();
    @(negedge clk);
    address = 4'd5; out_en = 1'b1; write_en = 1'b1; tb_oe = 1'b0; #1;
    tests++;
    if (data !== RELEASED) begin
      fails++; $display("FAIL contention_release: got %h expected %h", data, RELEASED);
    end
    tb_wdata = 8'h3C; tb_oe = 1'b1; #1;
    tests++;
    if (data !== 8'h3C) begin
      fails++; $display("FAIL contention_bus: got %h expected 3c", data);
    end
    @(posedge clk);
    model[5] = 8'h3C;
    #1;
    write_en = 1'b0; tb_oe = 1'b0; #1;
    tests++;
    if (data !== 8'h3C) begin
      fails++; $display("FAIL contention_read@5: got %h expected 3c", data);
    end
    out_en = 1'b0;
    $display("[TB] test_contention done");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [6] = '{4'd2, 4'd9, 4'd2, 4'd9, 4'd2, 4'd7};
    logic [DW-1:0] v;
    @(negedge clk);
    write_en = 1'b1; out_en = 1'b0; tb_oe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = DW'($urandom_range(0, 254));
      address = addrs[i]; tb_wdata = v;
      @(posedge clk);
      model[addrs[i]] = v;
      @(negedge clk);
    end
    write_en = 1'b0; tb_oe = 1'b0; out_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = addrs[i + 3]; #1;
      tests++;
      if (data !== model[addrs[i + 3]]) begin
        fails++; $display("FAIL b2b_read@%0d: got %h expected %h", addrs[i + 3], data, model[addrs[i + 3]]);
      end
    end
    out_en = 1'b0;
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int n = 0; n < 80; n++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      v = DW'($urandom_range(0, 254));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, v);
      end else begin
        out_en = 1'b1; address = a; #1;
        tests++;
        if (data !== model[a]) begin
          fails++; $display("FAIL random_read@%0d: got %h expected %h", a, data, model[a]);
        end
        out_en = 1'b0;
      end
    end
    $display("[TB] test_random done");
  endtask

  task automatic test_async_reset();
    do_write(4'd5, 8'h3C);
    @(negedge clk);
    address = 4'd5; out_en = 1'b1; #1;
    tests++;
    if (data !== 8'h3C) begin
      fails++; $display("FAIL pre_reset_read@5: got %h expected 3c", data);
    end
    reset = 1'b1; #1;
    tests++;
    if (data !== RELEASED) begin
      fails++; $display("FAIL async_reset_release: got %h expected %h", data, RELEASED);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    address = 4'd9; tb_wdata = 8'hA5; tb_oe = 1'b1; write_en = 1'b1; out_en = 1'b0;
    @(posedge clk); #1;
    write_en = 1'b0; tb_oe = 1'b0; #2;
    reset = 1'b0; out_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i); #1;
      tests++;
      if (data !== model[i]) begin
        fails++; $display("FAIL post_reset_read@%0d: got %h expected %h", i, data, model[i]);
      end
    end
    out_en = 1'b0;
    $display("[TB] test_async_reset done");
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    do_write(4'd3, 8'h07);
    out_en = 1'b1; address = 4'd3; #1;
    tests++;
    if (parity_err !== 1'b0 || data !== 8'h07) begin
      fails++; $display("FAIL parity_clean: got err=%b data=%h expected err=0 data=07", parity_err, data);
    end
    force dut.g_word[3].word_q = 9'h106;
    #1;
    tests++;
    if (parity_err !== 1'b1) begin
      fails++; $display("FAIL parity_corrupt: got %b expected 1", parity_err);
    end
    out_en = 1'b0; #1;
    tests++;
    if (parity_err !== 1'b0) begin
      fails++; $display("FAIL parity_out_en0: got %b expected 0", parity_err);
    end
    release dut.g_word[3].word_q;
    do_write(4'd3, 8'h07);
    $display("[TB] test_parity done");
  endtask
`endif

  initial begin
    reset = 1'b0; out_en = 1'b0; write_en = 1'b0;
    address = '0; tb_oe = 1'b0; tb_wdata = '0;
    #2;
    test_reset();
    test_sequential_writes();
    test_overwrite_boundary();
    test_contention();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
